// File: rtl/enhanced_stopwatch_command_interface_if.sv
// RX FIFO read-side bundle between the UART receive FIFO and the command decoder.
// The FIFO side drives head byte and empty flag; the decoder drives the pop strobe.
interface enhanced_stopwatch_command_interface_if;
    logic       i_rx_empty;
    logic [7:0] i_rx_data;
    logic       o_rx_rd;

    modport master (output i_rx_empty, output i_rx_data, input o_rx_rd);
    modport slave  (input i_rx_empty, input i_rx_data, output o_rx_rd);
endinterface

// File: rtl/enhanced_stopwatch_command_interface.sv
// Stopwatch command decoder: pops ASCII bytes from the RX FIFO, decodes single-char
// commands and the "sD.DD.D" preset sequence, and drives stopwatch control pulses/levels.
module enhanced_stopwatch_command_interface #(
    parameter int unsigned TO_CYCLES = 100_000_000,
    parameter int unsigned TO_BITS   = 27
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    enhanced_stopwatch_command_interface_if.slave rx,
    output logic                                  o_clr,
    output logic                                  o_go,
    output logic                                  o_up,
    output logic                                  o_send,
    output logic                                  o_load,
    output logic [3:0]                            o_ld3,
    output logic [3:0]                            o_ld2,
    output logic [3:0]                            o_ld1,
    output logic [3:0]                            o_ld0,
    output logic                                  o_err
);

    typedef enum logic [2:0] {IDLE, P3, P2, P1, P0} state_t;

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TO_CYCLES - 1);

    state_t               state_q, state_d;
    logic [TO_BITS-1:0]   cnt_q, cnt_d;
    logic                 go_q, go_d, up_q, up_d;
    logic                 clr_q, clr_d, send_q, send_d, load_q, load_d, err_q, err_d;
    logic [3:0]           sh3_q, sh3_d, sh2_q, sh2_d, sh1_q, sh1_d;
    logic [3:0]           ld3_q, ld3_d, ld2_q, ld2_d, ld1_q, ld1_d, ld0_q, ld0_d;

    logic       pop;
    logic [7:0] byte_in;
    logic [7:0] ch;
    logic       is_digit;
    logic [3:0] digit;

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        to_lower = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    endfunction

    assign pop        = !rx.i_rx_empty;
    assign rx.o_rx_rd = pop;
    assign byte_in    = rx.i_rx_data;
    assign ch         = to_lower(byte_in);
    assign is_digit   = (byte_in >= 8'h30) && (byte_in <= 8'h39);
    assign digit      = byte_in[3:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_d    = go_q;
        up_d    = up_q;
        clr_d   = 1'b0;
        send_d  = 1'b0;
        load_d  = 1'b0;
        err_d   = 1'b0;
        sh3_d   = sh3_q;
        sh2_d   = sh2_q;
        sh1_d   = sh1_q;
        ld3_d   = ld3_q;
        ld2_d   = ld2_q;
        ld1_d   = ld1_q;
        ld0_d   = ld0_q;

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (pop) begin
                case (ch)
                    "c":                   clr_d  = 1'b1;
                    "g":                   go_d   = 1'b1;
                    "p":                   go_d   = 1'b0;
                    "u":                   up_d   = 1'b1;
                    "d":                   up_d   = 1'b0;
                    "r":                   send_d = 1'b1;
                    "s":                   state_d = P3;
                    8'h0A, 8'h0D, 8'h20: ;
                    default:               err_d  = 1'b1;
                endcase
            end
        end else if (pop) begin
            // '.' separators are skipped after the first digit without touching the timeout
            if (byte_in == 8'h2E && state_q != P3) begin
                cnt_d = cnt_q;
            end else if (is_digit && !(state_q == P2 && byte_in > 8'h35)) begin
                cnt_d = '0;
                case (state_q)
                    P3: begin sh3_d = digit; state_d = P2; end
                    P2: begin sh2_d = digit; state_d = P1; end
                    P1: begin sh1_d = digit; state_d = P0; end
                    default: begin
                        ld3_d   = sh3_q;
                        ld2_d   = sh2_q;
                        ld1_d   = sh1_q;
                        ld0_d   = digit;
                        load_d  = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end else begin
                cnt_d   = '0;
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end else if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            up_q    <= 1'b1;
            clr_q   <= 1'b0;
            send_q  <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            sh3_q   <= '0;
            sh2_q   <= '0;
            sh1_q   <= '0;
            ld3_q   <= '0;
            ld2_q   <= '0;
            ld1_q   <= '0;
            ld0_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
            up_q    <= up_d;
            clr_q   <= clr_d;
            send_q  <= send_d;
            load_q  <= load_d;
            err_q   <= err_d;
            sh3_q   <= sh3_d;
            sh2_q   <= sh2_d;
            sh1_q   <= sh1_d;
            ld3_q   <= ld3_d;
            ld2_q   <= ld2_d;
            ld1_q   <= ld1_d;
            ld0_q   <= ld0_d;
        end
    end

    assign o_clr  = clr_q;
    assign o_go   = go_q;
    assign o_up   = up_q;
    assign o_send = send_q;
    assign o_load = load_q;
    assign o_err  = err_q;
    assign o_ld3  = ld3_q;
    assign o_ld2  = ld2_q;
    assign o_ld1  = ld1_q;
    assign o_ld0  = ld0_q;

endmodule

// File: tb/tb_enhanced_stopwatch_command_interface.sv
// Directed bench for the stopwatch command decoder: a vector table of single-byte
// steps plus hand-written timeout, pop-vs-timeout and mid-sequence reset sequences.
module tb_enhanced_stopwatch_command_interface;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       o_clr, o_go, o_up, o_send, o_load, o_err;
    logic [3:0] o_ld3, o_ld2, o_ld1, o_ld0;

    int checks = 0;
    int errors = 0;

    enhanced_stopwatch_command_interface_if rx_if ();

    enhanced_stopwatch_command_interface #(
        .TO_CYCLES (16),
        .TO_BITS   (5)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .rx      (rx_if),
        .o_clr   (o_clr),
        .o_go    (o_go),
        .o_up    (o_up),
        .o_send  (o_send),
        .o_load  (o_load),
        .o_ld3   (o_ld3),
        .o_ld2   (o_ld2),
        .o_ld1   (o_ld1),
        .o_ld0   (o_ld0),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        go, up, clr, send, load, err;
        logic [15:0] ld;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] d, input logic v, input logic go, input logic up,
                       input logic clr, input logic send, input logic load, input logic err,
                       input logic [15:0] ld);
        vec_t r;
        r.d = d; r.v = v; r.go = go; r.up = up; r.clr = clr;
        r.send = send; r.load = load; r.err = err; r.ld = ld;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: present one byte (or nothing) across the next rising edge.
    task automatic apply(input logic v, input logic [7:0] d);
        rx_if.i_rx_empty = !v;
        rx_if.i_rx_data  = d;
        #1 chk("o_rx_rd", {31'd0, rx_if.o_rx_rd}, {31'd0, v});
        @(negedge i_clk);
    endtask

    task automatic chk_all(input string tag, input logic go, input logic up, input logic clr,
                           input logic send, input logic load, input logic err,
                           input logic [15:0] ld);
        chk({tag, " go"},   {31'd0, o_go},   {31'd0, go});
        chk({tag, " up"},   {31'd0, o_up},   {31'd0, up});
        chk({tag, " clr"},  {31'd0, o_clr},  {31'd0, clr});
        chk({tag, " send"}, {31'd0, o_send}, {31'd0, send});
        chk({tag, " load"}, {31'd0, o_load}, {31'd0, load});
        chk({tag, " err"},  {31'd0, o_err},  {31'd0, err});
        chk({tag, " ld"},   {16'd0, o_ld3, o_ld2, o_ld1, o_ld0}, {16'd0, ld});
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) apply(1'b1, s[i]);
    endtask

    initial begin : main
        int err_at;
        rx_if.i_rx_empty = 1'b1;
        rx_if.i_rx_data  = 8'h00;

        //     byte   v  go up clr snd ld err ld3..0
        add("g",   1, 1, 1, 0, 0, 0, 0, 16'h0000);
        add("U",   1, 1, 1, 0, 0, 0, 0, 16'h0000);
        add("d",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add(8'h00, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
        add("r",   1, 1, 0, 0, 1, 0, 0, 16'h0000);
        add("c",   1, 1, 0, 1, 0, 0, 0, 16'h0000);
        add("P",   1, 0, 0, 0, 0, 0, 0, 16'h0000);
        add("G",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add(8'h0A, 1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add(8'h0D, 1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add(" ",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add("z",   1, 1, 0, 0, 0, 0, 1, 16'h0000);
        add("s",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add("3",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add(".",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add("4",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add("5",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add(".",   1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add("7",   1, 1, 0, 0, 0, 1, 0, 16'h3457);
        add(8'h00, 0, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("s",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("3",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("6",   1, 1, 0, 0, 0, 0, 1, 16'h3457);
        add("s",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("1",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("x",   1, 1, 0, 0, 0, 0, 1, 16'h3457);
        add("g",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("s",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("9",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("5",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("9",   1, 1, 0, 0, 0, 0, 0, 16'h3457);
        add("9",   1, 1, 0, 0, 0, 1, 0, 16'h9599);
        add("s",   1, 1, 0, 0, 0, 0, 0, 16'h9599);
        add(".",   1, 1, 0, 0, 0, 0, 1, 16'h9599);
        add("S",   1, 1, 0, 0, 0, 0, 0, 16'h9599);
        add("0",   1, 1, 0, 0, 0, 0, 0, 16'h9599);
        add("0",   1, 1, 0, 0, 0, 0, 0, 16'h9599);
        add("0",   1, 1, 0, 0, 0, 0, 0, 16'h9599);
        add("0",   1, 1, 0, 0, 0, 1, 0, 16'h0000);
        add("u",   1, 1, 1, 0, 0, 0, 0, 16'h0000);
        add("c",   1, 1, 1, 1, 0, 0, 0, 16'h0000);
        add("c",   1, 1, 1, 1, 0, 0, 0, 16'h0000);

        @(negedge i_clk);
        apply(1'b0, 8'h00);
        apply(1'b0, 8'h00);
        i_reset = 1'b0;
        chk_all("reset", 0, 1, 0, 0, 0, 0, 16'h0000);

        foreach (vecs[i]) begin
            apply(vecs[i].v, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].go, vecs[i].up, vecs[i].clr,
                    vecs[i].send, vecs[i].load, vecs[i].err, vecs[i].ld);
        end

        // Timeout: error must appear on exactly the 16th idle cycle after the last pop.
        push_str("ps1");
        err_at = 0;
        for (int k = 1; k <= 20; k++) begin
            apply(1'b0, 8'h00);
            if (o_err && err_at == 0) err_at = k;
        end
        chk("timeout cycles", err_at, 16);
        chk("timeout ld", {16'd0, o_ld3, o_ld2, o_ld1, o_ld0}, 32'h0000);
        apply(1'b1, "g");
        chk_all("after timeout g", 1, 1, 0, 0, 0, 0, 16'h0000);

        // A pop on the cycle the timeout would fire wins.
        apply(1'b1, "s");
        for (int k = 1; k <= 15; k++) begin
            apply(1'b0, 8'h00);
            chk("no early timeout", {31'd0, o_err}, 32'd0);
        end
        apply(1'b1, "1");
        chk("pop wins err", {31'd0, o_err}, 32'd0);
        push_str("234");
        chk_all("pop wins load", 1, 1, 0, 0, 1, 0, 16'h1234);

        // Reset mid-sequence discards the preset and restores defaults.
        push_str("ds12");
        i_reset = 1'b1;
        apply(1'b0, 8'h00);
        i_reset = 1'b0;
        chk_all("mid reset", 0, 1, 0, 0, 0, 0, 16'h0000);
        apply(1'b1, "5");
        chk_all("post reset 5", 0, 1, 0, 0, 0, 1, 16'h0000);
        apply(1'b0, 8'h00);
        chk_all("err one cycle", 0, 1, 0, 0, 0, 0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
